// File: rtl/fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_int
//  Description : Multi-cycle IEEE-754 binary32 to signed 32-bit integer
//                converter with five rounding modes, invalid/inexact flags
//                and a start/busy/done handshake. The alignment shifter
//                moves one bit per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_to_int #(
  parameter int W = 32,  // word width, only 32 supported
  parameter int M = 22,  // MSB index of fraction field
  parameter int E = 30   // MSB index of exponent field
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_in,
  input  logic [2:0]   i_round_m,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_out,
  output logic         o_inv,
  output logic         o_inexact
);

  // Rounding mode encodings shared with the FPU arithmetic units
  localparam logic [2:0] c_RM_RNE = 3'd0;
  localparam logic [2:0] c_RM_RNA = 3'd1;
  localparam logic [2:0] c_RM_RZ  = 3'd2;
  localparam logic [2:0] c_RM_RU  = 3'd3;
  localparam logic [2:0] c_RM_RD  = 3'd4;

  localparam logic [W-1:0] c_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_MAX_NEG = {1'b1, {(W-1){1'b0}}};
  // -2^31 is the only e=31 value that fits
  localparam logic [W-1:0] c_FP_INT_MIN = 32'hCF00_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0] r_in;
  logic [2:0]   r_rm;
  logic         r_sign;
  logic [W-1:0] r_mag;
  logic         r_guard;
  logic         r_sticky;
  logic         r_left;
  logic [4:0]   r_cnt;
  logic [W-1:0] r_out;
  logic         r_inv;
  logic         r_inexact;

  logic [E-M-1:0] w_exp;
  logic [M:0]     w_frac;
  logic           w_sign;
  logic           w_special;
  logic [W-1:0]   w_spec_out;
  logic           w_spec_inv;
  logic           w_spec_inx;
  logic           w_left;
  logic [4:0]     w_cnt;
  logic           w_inc;
  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_rounded;

  assign w_sign = r_in[W-1];
  assign w_exp  = r_in[E:M+1];
  assign w_frac = r_in[M:0];

  // Classify the captured operand and precompute special results and shift count
  always_comb begin
    w_special  = 1'b0;
    w_spec_out = '0;
    w_spec_inv = 1'b0;
    w_spec_inx = 1'b0;
    w_left     = 1'b0;
    w_cnt      = 5'd0;
    if (w_exp == 8'd255) begin
      w_special  = 1'b1;
      w_spec_inv = 1'b1;
      w_spec_out = (w_sign && (w_frac == '0)) ? c_MAX_NEG : c_MAX_POS;
    end else if ((w_exp > 8'd158) || ((w_exp == 8'd158) && (r_in != c_FP_INT_MIN))) begin
      w_special  = 1'b1;
      w_spec_inv = 1'b1;
      w_spec_out = w_sign ? c_MAX_NEG : c_MAX_POS;
    end else if (w_exp == 8'd0) begin
      w_special = 1'b1;
      if (w_frac != '0) begin
        w_spec_inx = 1'b1;
        if ((r_rm == c_RM_RU) && !w_sign)
          w_spec_out = {{(W-1){1'b0}}, 1'b1};
        else if ((r_rm == c_RM_RD) && w_sign)
          w_spec_out = {W{1'b1}};
      end
    end else if (w_exp >= 8'd150) begin
      // e >= 23: left shift by e-23; 150 mod 32 = 22 keeps it in 5 bits
      w_left = 1'b1;
      w_cnt  = w_exp[4:0] - 5'd22;
    end else if (w_exp <= 8'd125) begin
      // right shift distance capped at 25: everything is guard/sticky by then
      w_cnt = 5'd25;
    end else begin
      w_cnt = 5'd22 - w_exp[4:0];
    end
  end

  // Rounding increment and signed result from the aligned magnitude
  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      c_RM_RNE: w_inc = r_guard & (r_sticky | r_mag[0]);
      c_RM_RNA: w_inc = r_guard;
      c_RM_RU:  w_inc = (r_guard | r_sticky) & ~r_sign;
      c_RM_RD:  w_inc = (r_guard | r_sticky) & r_sign;
      default:  w_inc = 1'b0;
    endcase
    w_sum     = r_mag + {{(W-1){1'b0}}, w_inc};
    w_rounded = r_sign ? (~w_sum + {{(W-1){1'b0}}, 1'b1}) : w_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_special)           w_state_nxt = S_OUT;
        else if (w_cnt == 5'd0)  w_state_nxt = S_ROUND;
        else                     w_state_nxt = S_SHIFT;
      end
      S_SHIFT:  if (r_cnt == 5'd1) w_state_nxt = S_ROUND;
      S_ROUND:  w_state_nxt = S_OUT;
      S_OUT:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, decode, serial shift, round; results load on entry to OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in      <= '0;
      r_rm      <= 3'd0;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_left    <= 1'b0;
      r_cnt     <= 5'd0;
      r_out     <= '0;
      r_inv     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_in <= i_in;
            r_rm <= i_round_m;
          end
        end
        S_DECODE: begin
          r_sign   <= w_sign;
          r_mag    <= {{(W-M-2){1'b0}}, 1'b1, w_frac};
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
          r_left   <= w_left;
          r_cnt    <= w_cnt;
          if (w_special) begin
            r_out     <= w_spec_out;
            r_inv     <= w_spec_inv;
            r_inexact <= w_spec_inx;
          end
        end
        S_SHIFT: begin
          if (r_left) begin
            r_mag <= {r_mag[W-2:0], 1'b0};
          end else begin
            r_mag    <= {1'b0, r_mag[W-1:1]};
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
          r_cnt <= r_cnt - 5'd1;
        end
        S_ROUND: begin
          r_out     <= w_rounded;
          r_inv     <= 1'b0;
          r_inexact <= r_guard | r_sticky;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_OUT);
  assign o_out     = r_out;
  assign o_inv     = r_inv;
  assign o_inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_to_int
//  Description : Self-checking bench for fp_to_int: directed cases, a
//                mid-operation reset, an ignored start while busy and random
//                operands against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_to_int;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RNA = 3'd1;
  localparam logic [2:0] RZ  = 3'd2;
  localparam logic [2:0] RU  = 3'd3;
  localparam logic [2:0] RD  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_in = '0;
  logic [2:0]  i_round_m = '0;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_inv, o_inexact;
  logic [31:0] o_out;

  int npass = 0;
  int ntotal = 0;
  int nfail = 0;

  fp_to_int dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in      (i_in),
    .i_round_m (i_round_m),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_out     (o_out),
    .o_inv     (o_inv),
    .o_inexact (o_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact value mant*2^(e-23) split into integer and remainder
  function automatic void ref_model(input logic [31:0] x, input logic [2:0] rm,
                                    output logic [31:0] o, output logic iv, output logic ix);
    logic   s;
    int     ex, e, k;
    longint mant, ip, rem, half, r;
    logic   inc;
    s = x[31];
    ex = int'(x[30:23]);
    o = 32'd0; iv = 1'b0; ix = 1'b0;
    if (ex == 255) begin
      iv = 1'b1;
      o = (s && (x[22:0] == 23'd0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (ex == 0) begin
      if (x[22:0] != 23'd0) begin
        ix = 1'b1;
        if (rm == RU && !s) o = 32'd1;
        else if (rm == RD && s) o = 32'hFFFF_FFFF;
      end
    end else begin
      mant = longint'({1'b1, x[22:0]});
      e = ex - 127;
      if (e >= 23) begin
        if (e > 40) ip = 64'h0000_0100_0000_0000;
        else        ip = mant << (e - 23);
        rem = 0; half = 1;
      end else begin
        k = 23 - e;
        if (k > 60) k = 60;
        ip = mant >> k;
        rem = mant - (ip << k);
        half = 64'sd1 << (k - 1);
      end
      case (rm)
        RNE:     inc = (rem > half) || (rem == half && ip[0]);
        RNA:     inc = (rem != 0) && (rem >= half);
        RU:      inc = (rem != 0) && !s;
        RD:      inc = (rem != 0) && s;
        default: inc = 1'b0;
      endcase
      r = ip + (inc ? 64'sd1 : 64'sd0);
      if ((!s && r > 64'sd2147483647) || (s && r > 64'sd2147483648)) begin
        iv = 1'b1;
        o = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        ix = (rem != 0);
        o = s ? 32'(-r) : 32'(r);
      end
    end
  endfunction

  // Expected start-to-done latency from the operand class and shift distance
  function automatic int ref_latency(input logic [31:0] x);
    int ex, e, n;
    ex = int'(x[30:23]);
    if (ex == 0 || ex == 255 || ex > 158 || (ex == 158 && x != 32'hCF00_0000)) return 2;
    e = ex - 127;
    if (e >= 23) n = e - 23;
    else n = (23 - e > 25) ? 25 : 23 - e;
    return n + 3;
  endfunction

  // One conversion; optionally pulses start (with a decoy operand) at cycle poke
  task automatic run(input logic [31:0] x, input logic [2:0] rm, input int poke,
                     output logic [31:0] o, output logic iv, output logic ix, output int lat);
    int cyc;
    i_in = x; i_round_m = rm; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_in = 32'h4F00_0000; i_round_m = RU;
    cyc = 1;
    chk("busy_c1", {31'd0, o_busy}, 32'd1);
    while (o_done !== 1'b1 && cyc < 40) begin
      i_start = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    lat = cyc; o = o_out; iv = o_inv; ix = o_inexact;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("busy_after_done", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic expect_conv(input string tag, input logic [31:0] x, input logic [2:0] rm,
                             input int poke, input logic [31:0] eo, input logic ei,
                             input logic ex, input int elat);
    logic [31:0] o;
    logic iv, ix;
    int lat;
    run(x, rm, poke, o, iv, ix, lat);
    chk({tag, "_out"}, o, eo);
    chk({tag, "_inv"}, {31'd0, iv}, {31'd0, ei});
    chk({tag, "_inexact"}, {31'd0, ix}, {31'd0, ex});
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    logic [31:0] x, eo;
    logic [2:0]  rm;
    logic        ei, ex;
    bit          saw_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_out", o_out, 32'd0);
    chk("rst_inv", {31'd0, o_inv}, 32'd0);
    chk("rst_inexact", {31'd0, o_inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    expect_conv("p3_5_rne",  32'h4060_0000, RNE, 0, 32'd4, 1'b0, 1'b1, 25);
    expect_conv("p2_5_rne",  32'h4020_0000, RNE, 0, 32'd2, 1'b0, 1'b1, 25);
    expect_conv("p2_5_rna",  32'h4020_0000, RNA, 0, 32'd3, 1'b0, 1'b1, 25);
    expect_conv("p2_5_ru",   32'h4020_0000, RU,  0, 32'd3, 1'b0, 1'b1, 25);
    expect_conv("p2_5_rz",   32'h4020_0000, RZ,  0, 32'd2, 1'b0, 1'b1, 25);
    expect_conv("m1_5_rd",   32'hBFC0_0000, RD,  0, 32'hFFFF_FFFE, 1'b0, 1'b1, 26);
    expect_conv("m1_5_rz",   32'hBFC0_0000, RZ,  0, 32'hFFFF_FFFF, 1'b0, 1'b1, 26);
    expect_conv("m0_5_rne",  32'hBF00_0000, RNE, 0, 32'd0, 1'b0, 1'b1, 27);
    expect_conv("m0_5_rna",  32'hBF00_0000, RNA, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 27);
    expect_conv("int_min",   32'hCF00_0000, RNE, 0, 32'h8000_0000, 1'b0, 1'b0, 11);
    expect_conv("p2_31",     32'h4F00_0000, RNE, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    expect_conv("qnan",      32'h7FC0_0000, RNE, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    expect_conv("neg_inf",   32'hFF80_0000, RNE, 0, 32'h8000_0000, 1'b1, 1'b0, 2);
    expect_conv("denorm_ru", 32'h0000_0001, RU,  0, 32'd1, 1'b0, 1'b1, 2);
    expect_conv("neg_zero",  32'h8000_0000, RNA, 0, 32'd0, 1'b0, 1'b0, 2);
    expect_conv("q_ru_n25",  32'h3E80_0000, RU,  0, 32'd1, 1'b0, 1'b1, 28);
    expect_conv("big_exact", 32'h4B7F_FFFF, RNE, 0, 32'h00FF_FFFF, 1'b0, 1'b0, 3);
    // start pulsed while busy must not disturb the running conversion
    expect_conv("busy_start", 32'h4060_0000, RNE, 5, 32'd4, 1'b0, 1'b1, 25);

    // Reset in the middle of a conversion aborts it without a done
    i_in = 32'h4B7F_FFFF; i_round_m = RNE; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    saw_done = (o_done === 1'b1);
    @(posedge clk); #1;
    saw_done = saw_done || (o_done === 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_out", o_out, 32'd0);
    chk("abort_inv", {31'd0, o_inv}, 32'd0);
    chk("abort_inexact", {31'd0, o_inexact}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      saw_done = saw_done || (o_done === 1'b1);
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Random operands, half with exponents near the integer range
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      if (i % 2 == 0) x[30:23] = 8'(120 + $urandom_range(0, 42));
      rm = 3'($urandom_range(0, 7));
      ref_model(x, rm, eo, ei, ex);
      expect_conv("rand", x, rm, 0, eo, ei, ex, ref_latency(x));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
